spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
- Shares the single SPI master (the strt / data_in / CKP / CPH / MISO / MOSI / SCK / CS datapath) between N_REQ on-chip requesters.
- Performs round-robin arbitration and latches the winner's byte and SPI mode (CKP/CPH).
- Sequences the master through one 8-bit transfer, returns the received byte and the status, and aborts on a timeout.
- Sits between the CPU-side clients and the SPI master, in the same clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles in WAIT before abort (>= 2).
- PTR_W, $clog2(N_REQ), width of the round-robin pointer and grant index.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester level request; held until that requester's ack.
- req_data  in  8*N_REQ  byte to transmit; slice i belongs to requester i.
- req_ckp  in  N_REQ  requested SCK polarity per requester.
- req_cph  in  N_REQ  requested SCK phase per requester.
- grant  out  N_REQ  one-hot; the owner of the current transaction.
- ack  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  N_REQ  one-cycle timeout flag, coincident with ack.
- rx_data  out  8  received byte; valid in the ack cycle, held until the next RESP.
- busy  out  1  high in every state except IDLE.
- m_strt  out  1  one-cycle start pulse to the SPI master.
- m_data_in  out  8  byte to the master.
- m_ckp  out  1  CKP to the master.
- m_cph  out  1  CPH to the master.
- m_done  in  1  master pulse: transfer complete.
- m_rx_data  in  8  byte the master shifted in from MISO; valid with m_done.

Behaviour:
- Reset: all outputs 0; state IDLE; ptr 0; timer 0; latched data/mode 0. Reset mid-transaction aborts it with no ack; the master shares rst.
- States: IDLE -> SETUP -> START -> WAIT -> RESP -> GAP -> IDLE.
- IDLE:
  - Winner = first set req bit searching ptr, ptr+1, ... with wrap mod N_REQ.
  - If any req is set, latch idx, req_data[idx], req_ckp[idx] and req_cph[idx], then go to SETUP.
  - No req: stay in IDLE.
- SETUP (1 cycle):
  - grant[idx]=1 from here through RESP inclusive.
  - m_ckp, m_cph and m_data_in driven from the latches, so the SCK idle level settles one cycle before start.
- START (1 cycle): m_strt=1; timer cleared to 0.
- WAIT:
  - timer increments each cycle.
  - m_done=1: latch m_rx_data, clear errflag, go to RESP.
  - Else timer==TIMEOUT-1: set errflag, leave rx_data unchanged, go to RESP.
  - m_done and timeout in the same cycle: done wins, err=0.
- RESP (1 cycle): ack[idx]=1; err[idx]=errflag; ptr <= (idx+1) mod N_REQ.
- GAP (1 cycle): grant=0. The requester must deassert req on the edge after its ack, and GAP prevents re-granting a stale req.
- Latency:
  - req first seen in IDLE at edge k: grant at k+1, m_strt at k+2, earliest ack at k+4 (m_done in the first WAIT cycle).
  - Back-to-back transactions: a new grant no sooner than 3 cycles after ack.
- m_data_in, m_ckp and m_cph hold their last values in IDLE and GAP and never change during SETUP..WAIT.
- req, req_data and mode changes after latching are ignored until the next IDLE.
- Owner drops req mid-transaction: the transaction completes and ack is still pulsed.
- m_done outside WAIT is ignored.
- Fairness: a continuously requesting client waits at most N_REQ-1 transactions.

Decomposition:
- Package spi_ctrl_pkg:
  - state enum (IDLE, SETUP, START, WAIT, RESP, GAP), 3-bit encoding.
  - SPI_DATA_W = 8.
  - Mode bit positions for {CKP, CPH}.
- Sub-module rr_arbiter:
  - Combinational rotating-priority pick.
  - Inputs: req and ptr. Outputs: valid and idx.
  - Instantiated once; the top holds the FSM, latches, timer and pointer.

Test Plan:
- Single request: req=0001, data0=0xA5, ckp0=1, cph0=0; m_done with m_rx_data=0x3C two cycles after m_strt -> m_data_in=0xA5, m_ckp=1, m_cph=0 held; grant=0001; ack=0001 with rx_data=0x3C; err=0.
- Round robin: req=1111 held, each req bit re-asserted after its ack -> grant order 0001, 0010, 0100, 1000, 0001; ptr wraps 3->0.
- Timeout: TIMEOUT=8, req=0100, m_done never asserted -> ack=0100 and err=0100 exactly 8 cycles after m_strt; rx_data keeps its previous value.
- Collision: m_done asserted in the cycle timer==TIMEOUT-1 -> ack pulsed, err=0, rx_data updated.
- Reset mid-WAIT: rst=1 for one cycle -> next cycle all outputs 0, state IDLE, ptr 0; no ack issued.
- Stray/late events: m_done pulsed in IDLE is ignored; owner drops req during WAIT and the transaction still acks; req data changed after SETUP leaves m_data_in unchanged.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI arbiter slice: FSM state encoding,
// SPI byte width and the bit positions of {CKP, CPH} in the latched mode.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam int SPI_DATA_W   = 8;
    localparam int MODE_W       = 2;
    localparam int MODE_CKP_BIT = 1;
    localparam int MODE_CPH_BIT = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: the first set request found when
// searching from ptr upward, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(N_REQ)) begin
                sum = sum - (PTR_W + 1)'(N_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin front end for a single SPI master: picks a requester, latches its
// byte and mode, runs one 8-bit transfer with a timeout and returns the result.
module spi_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    parameter int PTR_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [8*N_REQ-1:0]      req_data,
    input  logic [N_REQ-1:0]        req_ckp,
    input  logic [N_REQ-1:0]        req_cph,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic [SPI_DATA_W-1:0]   rx_data,
    output logic                    busy,
    output logic                    m_strt,
    output logic [SPI_DATA_W-1:0]   m_data_in,
    output logic                    m_ckp,
    output logic                    m_cph,
    input  logic                    m_done,
    input  logic [SPI_DATA_W-1:0]   m_rx_data
);

    localparam int TMR_W = $clog2(TIMEOUT);

    state_t                 state;
    state_t                 state_nxt;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       idx_q;
    logic [SPI_DATA_W-1:0]  data_q;
    logic [MODE_W-1:0]      mode_q;
    logic [TMR_W-1:0]       timer;
    logic                   err_flag;
    logic [SPI_DATA_W-1:0]  rx_q;

    logic                   arb_valid;
    logic [PTR_W-1:0]       arb_idx;
    logic                   timed_out;
    logic [PTR_W-1:0]       idx_next;
    logic [N_REQ-1:0]       owner;
    logic [SPI_DATA_W-1:0]  req_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*SPI_DATA_W +: SPI_DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign timed_out = (timer == TMR_W'(TIMEOUT - 1));
    assign idx_next  = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign owner     = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;

    assign m_data_in = data_q;
    assign m_ckp     = mode_q[MODE_CKP_BIT];
    assign m_cph     = mode_q[MODE_CPH_BIT];
    assign rx_data   = rx_q;

    // The timer reads 0 during START and counts through WAIT, so a transfer that
    // never completes is answered TIMEOUT cycles after the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            mode_q   <= '0;
            timer    <= '0;
            err_flag <= 1'b0;
            rx_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        idx_q                <= arb_idx;
                        data_q               <= req_bytes[arb_idx];
                        mode_q[MODE_CKP_BIT] <= req_ckp[arb_idx];
                        mode_q[MODE_CPH_BIT] <= req_cph[arb_idx];
                    end
                end
                SETUP: timer <= '0;
                START: timer <= timer + 1'b1;
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (m_done) begin
                        rx_q     <= m_rx_data;
                        err_flag <= 1'b0;
                    end else if (timed_out) begin
                        err_flag <= 1'b1;
                    end
                end
                RESP: ptr <= idx_next;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = '0;
        ack       = '0;
        err       = '0;
        m_strt    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (arb_valid) state_nxt = SETUP;
            end
            SETUP: begin
                grant     = owner;
                state_nxt = START;
            end
            START: begin
                grant     = owner;
                m_strt    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                grant = owner;
                if (m_done || timed_out) state_nxt = RESP;
            end
            RESP: begin
                grant     = owner;
                ack       = owner;
                err       = err_flag ? owner : '0;
                state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a hand-driven SPI master response with
// expected grants, latencies, acks and received bytes worked out by hand.
module tb_spi_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 8;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_ckp;
    logic [NR-1:0] req_cph;
    logic [NR-1:0] grant;
    logic [NR-1:0] ack;
    logic [NR-1:0] err;
    logic [7:0]    rx_data;
    logic          busy;
    logic          m_strt;
    logic [7:0]    m_data_in;
    logic          m_ckp;
    logic          m_cph;
    logic          m_done;
    logic [7:0]    m_rx_data;

    int total_checks;
    int passed_checks;

    spi_arbiter #(
        .N_REQ   (NR),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_ckp   (req_ckp),
        .req_cph   (req_cph),
        .grant     (grant),
        .ack       (ack),
        .err       (err),
        .rx_data   (rx_data),
        .busy      (busy),
        .m_strt    (m_strt),
        .m_data_in (m_data_in),
        .m_ckp     (m_ckp),
        .m_cph     (m_cph),
        .m_done    (m_done),
        .m_rx_data (m_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic applyStimulus(input int who, input logic [7:0] data, input logic ckp, input logic cph);
        req_data[who*8 +: 8] = data;
        req_ckp[who]         = ckp;
        req_cph[who]         = cph;
        req[who]             = 1'b1;
    endtask

    // One full transaction: SETUP checks, START pulse, master reply after done_at
    // WAIT cycles (0 = never), RESP checks, then the GAP cycle.
    task automatic doTransfer(input string tag, input logic [3:0] exp_grant,
                              input logic [7:0] exp_data, input logic exp_ckp, input logic exp_cph,
                              input int exp_wait, input int done_at, input logic [7:0] rx_byte,
                              input logic exp_err, input logic [7:0] exp_rx,
                              input logic disturb, input logic rearm);
        int wait_n;
        int n;
        int exp_n;
        wait_n = 0;
        do begin
            step();
            wait_n++;
        end while (grant == '0 && wait_n < 10);
        checkOutput({tag, ".grant_lat"}, wait_n, exp_wait);
        checkOutput({tag, ".grant"}, {28'd0, grant}, {28'd0, exp_grant});
        checkOutput({tag, ".setup_out"}, {21'd0, m_data_in, m_ckp, m_cph, m_strt},
                    {21'd0, exp_data, exp_ckp, exp_cph, 1'b0});
        step();
        checkOutput({tag, ".strt"}, {31'd0, m_strt}, 32'd1);
        n = 0;
        do begin
            step();
            n++;
            if (ack == '0) begin
                if (disturb && n == 1) begin
                    req      = '0;
                    req_data = {NR{8'hEE}};
                    req_ckp  = ~req_ckp;
                    req_cph  = ~req_cph;
                end
                m_done    = (n == done_at);
                m_rx_data = (n == done_at) ? rx_byte : 8'h77;
            end
        end while (ack == '0 && n < 40);
        m_done    = 1'b0;
        m_rx_data = 8'h00;
        exp_n = (done_at == 0) ? TMO : done_at + 1;
        checkOutput({tag, ".ack_lat"}, n, exp_n);
        checkOutput({tag, ".ack"}, {28'd0, ack}, {28'd0, exp_grant});
        checkOutput({tag, ".err"}, {28'd0, err}, {28'd0, (exp_err ? exp_grant : 4'b0000)});
        checkOutput({tag, ".rx"}, {24'd0, rx_data}, {24'd0, exp_rx});
        checkOutput({tag, ".held"}, {22'd0, m_data_in, m_ckp, m_cph, grant == exp_grant},
                    {22'd0, exp_data, exp_ckp, exp_cph, 1'b1});
        req = req & ~exp_grant;
        step();
        checkOutput({tag, ".gap"}, {23'd0, grant, ack, busy}, {23'd0, 4'b0000, 4'b0000, 1'b1});
        if (rearm) req = req | exp_grant;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] ack_seen;
        total_checks  = 0;
        passed_checks = 0;
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        req_ckp   = '0;
        req_cph   = '0;
        m_done    = 1'b0;
        m_rx_data = 8'h00;

        $display("[TB] reset state");
        step();
        step();
        rst = 1'b0;
        checkOutput("reset.ctl", {17'd0, grant, ack, err, busy, m_strt, m_ckp, m_cph}, 32'd0);
        checkOutput("reset.data", {16'd0, rx_data, m_data_in}, 32'd0);

        $display("[TB] single request");
        applyStimulus(0, 8'hA5, 1'b1, 1'b0);
        doTransfer("single", 4'b0001, 8'hA5, 1'b1, 1'b0, 1, 2, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0);

        $display("[TB] timeout");
        applyStimulus(2, 8'h5A, 1'b0, 1'b1);
        doTransfer("timeout", 4'b0100, 8'h5A, 1'b0, 1'b1, 2, 0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0);

        $display("[TB] done/timeout collision");
        applyStimulus(1, 8'h69, 1'b1, 1'b1);
        doTransfer("collide", 4'b0010, 8'h69, 1'b1, 1'b1, 2, TMO - 1, 8'h96, 1'b0, 8'h96, 1'b0, 1'b0);

        $display("[TB] stray m_done in IDLE");
        req = '0;
        step();
        m_done    = 1'b1;
        m_rx_data = 8'hFF;
        step();
        m_done    = 1'b0;
        m_rx_data = 8'h00;
        checkOutput("stray.idle", {23'd0, grant, ack, busy}, 32'd0);
        step();
        checkOutput("stray.rx", {23'd0, rx_data, busy}, {23'd0, 8'h96, 1'b0});

        $display("[TB] owner drops req and changes data mid-transfer");
        applyStimulus(2, 8'hC3, 1'b1, 1'b1);
        doTransfer("drop", 4'b0100, 8'hC3, 1'b1, 1'b1, 1, 1, 8'h11, 1'b0, 8'h11, 1'b1, 1'b0);

        $display("[TB] reset during WAIT");
        applyStimulus(3, 8'h4B, 1'b0, 1'b0);
        step();
        step();
        checkOutput("rstw.grant", {28'd0, grant}, {28'd0, 4'b1000});
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = '0;
        checkOutput("rstw.ctl", {17'd0, grant, ack, err, busy, m_strt, m_ckp, m_cph}, 32'd0);
        checkOutput("rstw.data", {16'd0, rx_data, m_data_in}, 32'd0);
        ack_seen  = '0;
        m_done    = 1'b1;
        m_rx_data = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            step();
            m_done   = 1'b0;
            ack_seen = ack_seen | ack;
        end
        checkOutput("rstw.no_ack", {27'd0, ack_seen, busy}, 32'd0);

        $display("[TB] round robin");
        for (int w = 0; w < NR; w++) begin
            applyStimulus(w, 8'h10 + 8'(w), w[0], w[1]);
        end
        for (int k = 0; k < 5; k++) begin
            int who;
            who = k % NR;
            doTransfer("rr", 4'(1 << who), 8'h10 + 8'(who), who[0], who[1],
                       (k == 0) ? 1 : 2, 1, 8'h80 + 8'(k), 1'b0, 8'h80 + 8'(k), 1'b0, 1'b1);
        end
        req = '0;

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
